pwm_gen_f: RTL and testbench
============================

// Module: pwm_gen_f
// PURPOSE
//  Consumer of the 3-bit duty level produced by the push-button up/down counter.
//  Resynchronises the level into the system clock domain and latches it once per PWM period.
//  Produces a glitch-free PWM waveform; sits between the level counter and the LED/motor pad.
// PARAMETERS
//  PRESCALE  1000  clk_f cycles per PWM step (>=2)
//  DUTY_W    3     duty_f width; steps per period STEP_MAX = 2**DUTY_W - 1 (7)
// PORTS
//  clk_f     in   1       system clock, rising edge
//  reset_f   in   1       reset, asynchronous, active-high
//  enable_f  in   1       run enable (sync to clk_f)
//  duty_f    in   DUTY_W  duty level from up/down counter (asynchronous to clk_f)
//  pwm_f     out  1       PWM output, registered
//  period_f  out  1       1-clk strobe at start of each PWM period
//  invert_f  in   1       output polarity select (only with PWM_INVERT_EN)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-period): pre_cnt=0, step_cnt=0, duty_shadow=0,
//    sync regs=0, state=IDLE, pwm_f=0, period_f=0. First edge after release: normal operation.
//  - Duty CDC: 2-flop sync of duty_f -> d_s2; d_stable updates only when d_s2 equals
//    previous d_s2 sample (two equal consecutive samples); duty_f change reaches d_stable in 3-4 clk.
//  - FSM IDLE: counters held 0, pwm_f=0, period_f=0. IDLE->RUN when enable_f=1:
//    that cycle loads duty_shadow<=d_stable, pulses period_f, step_cnt=0, pre_cnt=0.
//  - FSM RUN->IDLE when enable_f=0 (same edge): counters cleared, pwm_f=0 next clk.
//  - Prescaler: pre_cnt counts 0..PRESCALE-1, wraps; tick = (pre_cnt==PRESCALE-1).
//  - Step: on tick, step_cnt increments; at STEP_MAX-1 wraps to 0 = period boundary:
//    duty_shadow<=d_stable, period_f=1 for exactly 1 clk (registered, same edge as wrap).
//  - Period = STEP_MAX*PRESCALE clk (7000 default).
//  - pwm_f <= (state==RUN) && (step_cnt < duty_shadow); 1 clk after step_cnt update.
//  - Duty 0: pwm_f constant 0. Duty STEP_MAX: pwm_f constant 1 in RUN (no pulse gaps at wrap).
//  - Duty changes mid-period: ignored until next boundary (no runt pulses).
//  - Compare widths: step_cnt and duty_shadow both DUTY_W bits, unsigned.
//  - pre_cnt width = clog2(PRESCALE); no overflow beyond PRESCALE-1.
// CONFIGURATION
//  PWM_INVERT_EN defined: invert_f port exists; pwm_f = raw ^ invert_f (registered);
//    in IDLE/reset pwm_f = invert_f registered value (reset value 0 -> goes 1 clk after
//    release if invert_f=1).
//  PWM_INVERT_EN undefined: no invert_f port; pwm_f active-high as above.
// TESTING (PRESCALE=4, DUTY_W=3, period 28 clk)
//  duty_f=3, enable_f=1 -> pwm_f high 12 clk, low 16 clk; period_f every 28 clk.
//  duty_f=0 then 7 -> pwm_f stays 0 whole period; after next boundary constant 1, period_f still every 28.
//  duty_f 2->5 at step 1 -> current period 8 clk high; next period 20 clk high.
//  reset_f pulse mid-high phase -> pwm_f=0 and period_f=0 immediately (no clk); restart with period_f.
//  enable_f 1->0 mid-period -> pwm_f=0 next clk; re-enable -> period_f same edge, new period from step 0.
//  PWM_INVERT_EN, invert_f=1, duty_f=3 -> pwm_f low 12 clk, high 16 clk.

Source files
------------

// File: rtl/pwm_gen_f.sv
// PWM generator: resynchronises an asynchronous duty level and latches it once per period.
// Optional output polarity select is enabled by defining PWM_INVERT_EN.
module pwm_gen_f #(
    parameter int PRESCALE = 1000,
    parameter int DUTY_W   = 3
) (
    input  logic              clk_f,
    input  logic              reset_f,
    input  logic              enable_f,
    input  logic [DUTY_W-1:0] duty_f,
`ifdef PWM_INVERT_EN
    input  logic              invert_f,
`endif
    output logic              pwm_f,
    output logic              period_f
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] STEP_LAST = DUTY_W'((1 << DUTY_W) - 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg;
    logic [PRE_W-1:0]  pre_cnt_reg;
    logic [DUTY_W-1:0] step_cnt_reg;
    logic [DUTY_W-1:0] duty_shadow_reg;
    logic [DUTY_W-1:0] d_s1_reg;
    logic [DUTY_W-1:0] d_s2_reg;
    logic [DUTY_W-1:0] d_prev_reg;
    logic [DUTY_W-1:0] d_stable_reg;
    logic              pol;

`ifdef PWM_INVERT_EN
    assign pol = invert_f;
`else
    assign pol = 1'b0;
`endif

    // Multi-bit level crosses asynchronously: only accept it once two
    // consecutive synchronised samples agree, so a skewed transition is never latched.
    always_ff @(posedge clk_f or posedge reset_f) begin
        if (reset_f) begin
            d_s1_reg     <= '0;
            d_s2_reg     <= '0;
            d_prev_reg   <= '0;
            d_stable_reg <= '0;
        end else begin
            d_s1_reg   <= duty_f;
            d_s2_reg   <= d_s1_reg;
            d_prev_reg <= d_s2_reg;
            if (d_s2_reg == d_prev_reg) begin
                d_stable_reg <= d_s2_reg;
            end
        end
    end

    always_ff @(posedge clk_f or posedge reset_f) begin
        if (reset_f) begin
            state_reg       <= IDLE;
            pre_cnt_reg     <= '0;
            step_cnt_reg    <= '0;
            duty_shadow_reg <= '0;
            period_f        <= 1'b0;
            pwm_f           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    pre_cnt_reg  <= '0;
                    step_cnt_reg <= '0;
                    pwm_f        <= pol;
                    period_f     <= 1'b0;
                    if (enable_f) begin
                        state_reg       <= RUN;
                        duty_shadow_reg <= d_stable_reg;
                        period_f        <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable_f) begin
                        state_reg    <= IDLE;
                        pre_cnt_reg  <= '0;
                        step_cnt_reg <= '0;
                        pwm_f        <= pol;
                        period_f     <= 1'b0;
                    end else begin
                        // Compare uses the pre-update step so the output trails the counter by one clock.
                        pwm_f    <= (step_cnt_reg < duty_shadow_reg) ^ pol;
                        period_f <= 1'b0;
                        if (pre_cnt_reg == PRE_LAST) begin
                            pre_cnt_reg <= '0;
                            if (step_cnt_reg == STEP_LAST) begin
                                step_cnt_reg    <= '0;
                                duty_shadow_reg <= d_stable_reg;
                                period_f        <= 1'b1;
                            end else begin
                                step_cnt_reg <= step_cnt_reg + DUTY_W'(1);
                            end
                        end else begin
                            pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    pwm_f     <= 1'b0;
                    period_f  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_gen_f.sv
// Scoreboard bench for pwm_gen_f: a period-level timeline model predicts every clock's outputs.
module tb_pwm_gen_f;

    localparam int P      = 4;
    localparam int DW     = 3;
    localparam int STEPS  = (1 << DW) - 1;
    localparam int PERIOD = STEPS * P;

    logic          clk_f;
    logic          reset_f;
    logic          enable_f;
    logic [DW-1:0] duty_f;
    logic          pwm_f;
    logic          period_f;
`ifdef PWM_INVERT_EN
    logic          invert_f;
`endif

    pwm_gen_f #(.PRESCALE(P), .DUTY_W(DW)) dut (
        .clk_f    (clk_f),
        .reset_f  (reset_f),
        .enable_f (enable_f),
        .duty_f   (duty_f),
`ifdef PWM_INVERT_EN
        .invert_f (invert_f),
`endif
        .pwm_f    (pwm_f),
        .period_f (period_f)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cycle  = 0;
    int n_period = 0;

    logic [1:0] exp_q[$];

    logic          en_v   = 1'b0;
    logic          rst_v  = 1'b1;
    logic [DW-1:0] duty_v = '0;

    // Timeline model: position within the current period and the duty latched at its start.
    bit m_run   = 1'b0;
    int m_t     = 0;
    int m_d     = 0;
    int m_prevd = 0;

    task automatic cyc();
        logic ep;
        logic epw;
        @(negedge clk_f);
        reset_f  = rst_v;
        enable_f = en_v;
        duty_f   = duty_v;
        ep  = 1'b0;
        epw = 1'b0;
        if (rst_v) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (en_v) begin
                m_run = 1'b1;
                m_t   = 0;
                m_d   = int'(duty_v);
                ep    = 1'b1;
            end
        end else if (!en_v) begin
            m_run = 1'b0;
        end else begin
            m_t++;
            if (m_t == PERIOD) begin
                m_t     = 0;
                m_prevd = m_d;
                m_d     = int'(duty_v);
                ep      = 1'b1;
                epw     = (PERIOD <= m_prevd * P);
            end else begin
                epw = (m_t <= m_d * P);
            end
        end
        exp_q.push_back({ep, epw});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // One full period from its start; the next duty is applied well away from both boundaries.
    task automatic period(input logic [DW-1:0] nd);
        run(6);
        duty_v = nd;
        run(PERIOD - 6);
    endtask

    // Monitor: outputs are presented every clock, popped and compared one step after the edge.
    initial begin
        logic [1:0] e;
        forever begin
            @(posedge clk_f);
            #1;
            n_cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({period_f, pwm_f} !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: pwm_f=%b period_f=%b, expected pwm_f=%b period_f=%b",
                             n_cycle, pwm_f, period_f, e[0], e[1]);
                end
                if (e[1]) begin
                    n_period++;
                    $display("period %0d starts at cycle %0d: pwm_f=%b period_f=%b",
                             n_period, n_cycle, pwm_f, period_f);
                end
            end
        end
    end

    initial begin
        int k;
`ifdef PWM_INVERT_EN
        invert_f = 1'b0;
`endif
        reset_f  = 1'b1;
        enable_f = 1'b0;
        duty_f   = '0;

        rst_v = 1'b1;
        run(3);
        rst_v  = 1'b0;
        duty_v = 3'd3;
        run(10);

        en_v = 1'b1;
        period(3'd3);
        period(3'd0);
        period(3'd7);
        period(3'd7);
        period(3'd2);
        period(3'd5);
        period(3'd5);
        repeat (8) period(DW'($urandom_range(7, 0)));

        k = int'($urandom_range(20, 3));
        run(k);
        en_v = 1'b0;
        run(9);
        en_v = 1'b1;
        period(DW'($urandom_range(7, 1)));
        period(3'd5);

        // Asynchronous reset in the high phase of a duty-5 period.
        run(10);
        @(posedge clk_f);
        #3;
        reset_f = 1'b1;
        rst_v   = 1'b1;
        #1;
        n_checks++;
        if (pwm_f !== 1'b0 || period_f !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: pwm_f=%b period_f=%b, expected 0 0", pwm_f, period_f);
        end
        run(2);
        rst_v = 1'b0;
        en_v  = 1'b0;
        run(9);
        en_v = 1'b1;
        period(3'd4);
        period(3'd1);
        period(DW'($urandom_range(7, 0)));

        en_v = 1'b0;
        run(3);
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_f);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
